// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first. Bit timing is derived from edges of the
// SCLK_PULSE rate reference, which is synchronised and treated purely as data.
module spi_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PTR_W  = 8
) (
  input  logic              CTRL_CLK,
  input  logic              NRST,
  input  logic              SCLK_PULSE,
  input  logic              ENABLE,
  input  logic [DATA_W-1:0] MOSI_data,
  output logic [DATA_W-1:0] MISO_data,
  output logic [PTR_W-1:0]  master_stash_ptr,
  input  logic              MISO,
  output logic              CS,
  output logic              SCLK,
  output logic              MOSI
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StTransfer, StStop} state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  // Holds only the bits still to be sent; the MSB goes straight to MOSI at frame start.
  logic [DATA_W-2:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   miso_data_q, miso_data_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                tick;

  // One-cycle pulse per SCLK_PULSE edge, either direction.
  assign tick = s2_q ^ s3_q;

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_data_d = miso_data_q;
    ptr_d       = ptr_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
          if (ENABLE) begin
            tx_d    = MOSI_data[DATA_W-2:0];
            mosi_d  = MOSI_data[DATA_W-1];
            cs_d    = 1'b0;
            cnt_d   = '0;
            state_d = StTransfer;
          end
        end
        StTransfer: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], MISO};
          end else if (cnt_q != CntLast) begin
            sclk_d = 1'b0;
            cnt_d  = cnt_q + CntW'(1);
            mosi_d = tx_q[DATA_W-2];
            tx_d   = {tx_q[DATA_W-3:0], 1'b0};
          end else begin
            sclk_d      = 1'b0;
            miso_data_d = rx_q;
            ptr_d       = ptr_q + PTR_W'(1);
            state_d     = StStop;
          end
        end
        StStop: begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CTRL_CLK) begin
    if (NRST) begin
      state_q     <= StIdle;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      miso_data_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      s1_q        <= SCLK_PULSE;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      miso_data_q <= miso_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign CS               = cs_q;
  assign SCLK             = sclk_q;
  assign MOSI             = mosi_q;
  assign MISO_data        = miso_data_q;
  assign master_stash_ptr = ptr_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a slave model pushes each frame's expected bytes into a queue at
// CS fall; a monitor pops and compares when the frame pointer advances.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       nrst, sclk_pulse, enable;
  logic       miso = 1'b0;
  logic [7:0] mosi_data;
  logic [7:0] miso_data, ptr;
  logic       cs, sclk, mosi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(8), .PTR_W(8)) dut (
    .CTRL_CLK        (clk),
    .NRST            (nrst),
    .SCLK_PULSE      (sclk_pulse),
    .ENABLE          (enable),
    .MOSI_data       (mosi_data),
    .MISO_data       (miso_data),
    .master_stash_ptr(ptr),
    .MISO            (miso),
    .CS              (cs),
    .SCLK            (sclk),
    .MOSI            (mosi)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rate reference: toggles every `period` clocks, so one tick per `period` clocks.
  int period = 3;
  initial begin
    sclk_pulse = 1'b0;
    forever begin
      repeat (period) @(posedge clk);
      #1 sclk_pulse = ~sclk_pulse;
    end
  end

  bit churn = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1 if (churn && ($urandom % 4 == 0)) mosi_data = 8'($urandom);
    end
  end

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;
  exp_t sb_q[$];

  // Slave model: presents its byte MSB first, next bit after each SCLK fall.
  logic [7:0] mosi_at_edge;
  logic [7:0] slave_byte, slave_fixed;
  bit         fixed_en = 0;
  int         slave_idx;
  logic       s_cs, s_sclk;

  always @(posedge clk) mosi_at_edge <= mosi_data;

  always @(negedge clk) begin
    if (nrst) begin
      s_cs   = 1'b1;
      s_sclk = 1'b0;
      miso   = 1'b0;
    end else begin
      if (s_cs && !cs) begin
        slave_byte = fixed_en ? slave_fixed : 8'($urandom);
        slave_idx  = 0;
        miso       = slave_byte[7];
        sb_q.push_back('{tx: mosi_at_edge, rx: slave_byte});
      end else if (!cs && s_sclk && !sclk) begin
        slave_idx++;
        if (slave_idx < 8) miso = slave_byte[7-slave_idx];
      end
      s_cs   = cs;
      s_sclk = sclk;
    end
  end

  // Monitor
  int         frames_started, frames_done, rises, cs_low_cyc, cs_high_cyc, last_gap, exp_ptr;
  logic [7:0] mosi_acc, last_mosi_byte, last_ptr, last_miso;
  logic       m_cs, m_sclk, m_mosi;
  exp_t       e;

  always @(negedge clk) begin
    if (nrst) begin
      frames_started = 0;
      frames_done    = 0;
      rises          = 0;
      exp_ptr        = 0;
      last_ptr       = 8'h00;
      last_miso      = 8'h00;
      m_cs           = 1'b1;
      m_sclk         = 1'b0;
      m_mosi         = 1'b0;
      cs_low_cyc     = 0;
      cs_high_cyc    = 0;
    end else begin
      if (m_cs && !cs) begin
        frames_started++;
        last_gap   = cs_high_cyc;
        rises      = 0;
        mosi_acc   = 8'h00;
        cs_low_cyc = 0;
      end
      if (!m_cs && cs) begin
        check("cs_low_len", cs_low_cyc, 17 * period);
        cs_high_cyc = 0;
      end
      if (mosi != m_mosi) check("mosi_change_edge", int'((m_cs != cs) || (m_sclk && !sclk)), 1);
      if (!m_sclk && sclk) begin
        rises++;
        mosi_acc = {mosi_acc[6:0], mosi};
      end
      if (miso_data != last_miso) check("miso_data_with_ptr", int'(ptr != last_ptr), 1);
      if (ptr != last_ptr) begin
        frames_done++;
        exp_ptr = (exp_ptr + 1) % 256;
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("frame_miso_data", miso_data, e.rx);
          check("frame_mosi_bits", mosi_acc, e.tx);
        end
        check("frame_ptr", ptr, exp_ptr);
        check("frame_sclk_pulses", rises, 8);
        last_mosi_byte = mosi_acc;
      end
      if (cs) cs_high_cyc++;
      else cs_low_cyc++;
      m_cs      = cs;
      m_sclk    = sclk;
      m_mosi    = mosi;
      last_ptr  = ptr;
      last_miso = miso_data;
    end
  end

  function automatic int cnt_of(input int which);
    case (which)
      0:       return frames_started;
      1:       return frames_done;
      default: return rises;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int n, input int budget);
    int c = 0;
    while (cnt_of(which) < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    case (which)
      0:       check("wait_frames_started", cnt_of(which), n);
      1:       check("wait_frames_done", cnt_of(which), n);
      default: check("wait_sclk_rises", cnt_of(which), n);
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
    repeat (3) begin
      enable    = 1'($urandom);
      mosi_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_miso_data", miso_data, 0);
    check("rst_ptr", ptr, 0);
    nrst   = 1'b0;
    enable = 1'b0;
    sb_q.delete();
    // Let any tick caused by clearing the synchroniser pass before starting frames.
    repeat (3 * period + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    nrst      = 1'b1;
    enable    = 1'b0;
    mosi_data = 8'h00;

    // Single frame; a mid-frame MOSI_data change must not leak onto the wire.
    period = 3;
    do_reset();
    fixed_en    = 1;
    slave_fixed = 8'h3C;
    mosi_data   = 8'hA5;
    enable      = 1'b1;
    wait_cnt(0, 1, 200);
    enable    = 1'b0;
    mosi_data = 8'h5A;
    wait_cnt(1, 1, 400);
    repeat (2 * period + 2) @(negedge clk);
    check("single_ptr", ptr, 1);
    check("single_miso_data", miso_data, 8'h3C);
    check("single_mosi_bits", last_mosi_byte, 8'hA5);
    check("single_cs_idle", cs, 1);
    check("single_sclk_idle", sclk, 0);
    check("single_frames", frames_started, 1);
    fixed_en = 0;

    // Back-to-back frames with ENABLE held high.
    period = 4;
    do_reset();
    mosi_data = 8'h01;
    enable    = 1'b1;
    wait_cnt(0, 1, 200);
    mosi_data = 8'hFF;
    wait_cnt(0, 2, 400);
    enable = 1'b0;
    check("b2b_cs_gap", last_gap, period);
    wait_cnt(1, 2, 400);
    repeat (2 * period + 2) @(negedge clk);
    check("b2b_ptr", ptr, 2);
    check("b2b_miso_data", miso_data, slave_byte);
    check("b2b_mosi_bits", last_mosi_byte, 8'hFF);
    check("b2b_frames", frames_started, 2);

    // ENABLE dropped after three bits: frame completes, nothing follows.
    period = 2;
    do_reset();
    mosi_data = 8'($urandom);
    enable    = 1'b1;
    wait_cnt(0, 1, 200);
    wait_cnt(2, 3, 200);
    enable = 1'b0;
    wait_cnt(1, 1, 300);
    repeat (40) @(negedge clk);
    check("drop_frames", frames_started, 1);
    check("drop_ptr", ptr, 1);
    check("drop_cs", cs, 1);

    // Reset after five bits aborts without touching data or pointer.
    period = 3;
    do_reset();
    mosi_data = 8'($urandom);
    enable    = 1'b1;
    wait_cnt(0, 1, 200);
    enable = 1'b0;
    wait_cnt(2, 5, 300);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cs", cs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_miso_data", miso_data, 0);
    check("midrst_ptr", ptr, 0);
    do_reset();

    // 256 frames with MOSI_data churning: pointer wraps back to zero.
    period = 2;
    do_reset();
    churn  = 1;
    enable = 1'b1;
    wait_cnt(0, 256, 12000);
    enable = 1'b0;
    churn  = 0;
    wait_cnt(1, 256, 300);
    repeat (20) @(negedge clk);
    check("wrap_ptr", ptr, 0);
    check("wrap_frames", frames_started, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
